// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// types
//   Shared definitions for the low-speed USB receive path.
//   - line_state_t   : decoded {D+,D-} bus state (encoding equals {d_p,d_n})
//   - usb_rx_state_t : receive FSM states
//   - decode_line()  : maps a raw {d_p,d_n} pair to a line state, folding
//                      the illegal SE1 condition into SE0
// -----------------------------------------------------------------------------
package types;

    // Encoding is chosen so that the raw {d_p,d_n} pair maps directly.
    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        ACTIVE,
        EOP,
        ABORT
    } usb_rx_state_t;

    // Ones run length after which the next bit on the wire is a stuffed zero.
    localparam logic [2:0] STUFF_RUN = 3'd6;

    // SYNC needs at least this many decoded zeros before its closing one.
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd3;

    // SE1 is never legal on a healthy bus; treating it as SE0 makes a glitch
    // look like a bus reset/EOP rather than a data symbol.
    function automatic line_state_t decode_line(input logic [1:0] dpdn);
        line_state_t ls;
        case (dpdn)
            2'b01:   ls = J;
            2'b10:   ls = K;
            default: ls = SE0;
        endcase
        return ls;
    endfunction

endpackage

// File: rtl/usb_rx_dpll.sv
// -----------------------------------------------------------------------------
// usb_rx_dpll
//   Bit-timing recovery for the low-speed receiver. Synchronizes the
//   asynchronous D+/D- pair with two flops, decodes the line state, and runs
//   a free-wrapping phase counter that re-aligns on every line transition.
//   A sample strobe marks the middle of each bit cell.
//
//   Ports
//     clk        in   system clock
//     reset      in   synchronous active-high reset
//     d_p, d_n   in   raw USB D+/D- (asynchronous)
//     line_state out  synchronized, decoded line state (SE1 folded to SE0)
//     sample     out  one-cycle strobe at the mid-bit phase
// -----------------------------------------------------------------------------
module usb_rx_dpll
    import types::*;
#(
    parameter int CLK_PER_BIT  = 16,
    parameter int SAMPLE_PHASE = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_p,
    input  logic        d_n,
    output line_state_t line_state,
    output logic        sample
);

    localparam int PW = $clog2(CLK_PER_BIT);

    logic [1:0]    raw_pair;
    logic [1:0]    sync_pair;
    line_state_t   prev_q;
    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          line_change;

    assign raw_pair = {d_p, d_n};

    // Independent two-flop synchronizer per wire. A skew between the two
    // wires only produces a one-cycle intermediate state, which the phase
    // counter absorbs as an extra re-alignment.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= raw_pair[gi];
                    sync_q <= meta_q;
                end
            end
            assign sync_pair[gi] = sync_q;
        end
    endgenerate

    assign line_state  = decode_line(sync_pair);
    assign line_change = (line_state != prev_q);

    always_comb begin
        phase_d = phase_q + 1'b1;
        if (line_change || (phase_q == PW'(CLK_PER_BIT - 1))) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= SE0;
            phase_q <= '0;
        end else begin
            prev_q  <= line_state;
            phase_q <= phase_d;
        end
    end

    assign sample = (phase_q == PW'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_rx.sv
// -----------------------------------------------------------------------------
// usb_rx
//   Low-speed (1.5 Mbit/s) USB receive serial interface engine at 24 MHz.
//   Takes mid-bit samples from usb_rx_dpll, NRZI-decodes them, removes
//   stuffed bits, tracks SYNC/EOP and assembles bytes LSB first.
//
//   Ports
//     clk        in   system clock (24 MHz)
//     reset      in   synchronous active-high reset
//     d_p, d_n   in   raw USB D+/D- (asynchronous)
//     rx_data    out  last received byte, updated with rx_valid
//     rx_active  out  high from SYNC completion until EOP/abort completion
//     rx_valid   out  one-cycle pulse per received byte
//     rx_error   out  one-cycle pulse on stuff error or misaligned EOP
// -----------------------------------------------------------------------------
module usb_rx
    import types::*;
#(
    parameter int CLK_PER_BIT  = 16,
    parameter int SAMPLE_PHASE = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_p,
    input  logic       d_n,
    output logic [7:0] rx_data,
    output logic       rx_active,
    output logic       rx_valid,
    output logic       rx_error
);

    line_state_t   line_state;
    logic          sample;

    usb_rx_state_t state_q, state_d;
    line_state_t   prev_q, prev_d;     // previous J/K sample for NRZI
    logic [2:0]    zero_cnt_q, zero_cnt_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    j_cnt_q, j_cnt_d;
    logic          se0_seen_q, se0_seen_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          active_q, active_d;
    logic          error_q, error_d;
    logic          dec_bit;

    usb_rx_dpll #(
        .CLK_PER_BIT  (CLK_PER_BIT),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_dpll (
        .clk        (clk),
        .reset      (reset),
        .d_p        (d_p),
        .d_n        (d_n),
        .line_state (line_state),
        .sample     (sample)
    );

    // NRZI: no change between samples is a 1, a change is a 0.
    assign dec_bit = (line_state == prev_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        zero_cnt_d = zero_cnt_q;
        ones_cnt_d = ones_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        j_cnt_d    = j_cnt_q;
        se0_seen_d = se0_seen_q;
        shift_d    = shift_q;
        data_d     = data_q;
        active_d   = active_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                prev_d   = J;
                if (sample && (line_state == K)) begin
                    state_d    = SYNC;
                    zero_cnt_d = 3'd1;
                    prev_d     = K;
                end
            end

            SYNC: begin
                if (sample) begin
                    if (line_state == SE0) begin
                        state_d = IDLE;
                        prev_d  = J;
                    end else if (!dec_bit) begin
                        prev_d = line_state;
                        if (zero_cnt_q != 3'd7) begin
                            zero_cnt_d = zero_cnt_q + 3'd1;
                        end
                    end else if (zero_cnt_q >= SYNC_MIN_ZEROS) begin
                        state_d    = ACTIVE;
                        active_d   = 1'b1;
                        bit_cnt_d  = 3'd0;
                        ones_cnt_d = 3'd0;
                        prev_d     = line_state;
                    end else begin
                        state_d = IDLE;
                        prev_d  = J;
                    end
                end
            end

            ACTIVE: begin
                if (sample) begin
                    if (line_state == SE0) begin
                        state_d = EOP;
                        // A partial byte at EOP is dropped and flagged once.
                        if (bit_cnt_q != 3'd0) begin
                            error_d = 1'b1;
                        end
                    end else begin
                        prev_d = line_state;
                        if (ones_cnt_q == STUFF_RUN) begin
                            // This bit must be a stuffed zero; it never
                            // reaches the shift register.
                            if (dec_bit) begin
                                error_d    = 1'b1;
                                state_d    = ABORT;
                                j_cnt_d    = 3'd0;
                                se0_seen_d = 1'b0;
                            end else begin
                                ones_cnt_d = 3'd0;
                            end
                        end else begin
                            ones_cnt_d = dec_bit ? (ones_cnt_q + 3'd1) : 3'd0;
                            shift_d    = {dec_bit, shift_q[7:1]};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                data_d  = {dec_bit, shift_q[7:1]};
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
            end

            EOP: begin
                if (sample && (line_state != SE0)) begin
                    // Either J or K ends the packet; a K here does not
                    // start a new SYNC.
                    state_d  = IDLE;
                    active_d = 1'b0;
                    prev_d   = J;
                end
            end

            ABORT: begin
                if (sample) begin
                    case (line_state)
                        SE0: begin
                            se0_seen_d = 1'b1;
                            j_cnt_d    = 3'd0;
                        end
                        J: begin
                            if (se0_seen_q || (j_cnt_q == 3'd7)) begin
                                state_d  = IDLE;
                                active_d = 1'b0;
                                prev_d   = J;
                            end else begin
                                j_cnt_d = j_cnt_q + 3'd1;
                            end
                        end
                        default: begin
                            se0_seen_d = 1'b0;
                            j_cnt_d    = 3'd0;
                        end
                    endcase
                end
            end

            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
                prev_d   = J;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= J;
            zero_cnt_q <= 3'd0;
            ones_cnt_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            j_cnt_q    <= 3'd0;
            se0_seen_q <= 1'b0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            zero_cnt_q <= zero_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            j_cnt_q    <= j_cnt_d;
            se0_seen_q <= se0_seen_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
            error_q    <= error_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_active = active_q;
    assign rx_error  = error_q;

endmodule

// File: tb/tb_usb_rx.sv
// -----------------------------------------------------------------------------
// tb_usb_rx
//   Drives NRZI-encoded, bit-stuffed low-speed packets into usb_rx and checks
//   the received bytes against a scoreboard of expected bytes and their
//   expected arrival cycles.
// -----------------------------------------------------------------------------
module tb_usb_rx;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       d_p   = 1'b0;
    logic       d_n   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_active;
    logic       rx_valid;
    logic       rx_error;

    usb_rx dut (
        .clk       (clk),
        .reset     (reset),
        .d_p       (d_p),
        .d_n       (d_n),
        .rx_data   (rx_data),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         exp_cyc;   // -1: arrival time not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   valid_cycs[$];
    int   valid_cnt  = 0;
    int   err_cnt    = 0;
    int   active_cnt = 0;
    int   rise_cyc   = -1;
    int   fall_cyc   = -1;
    logic active_prev = 1'b0;
    logic pulse_prev  = 1'b0;

    // Output monitor: samples on the falling edge, pops the scoreboard on
    // every rx_valid.
    always @(negedge clk) begin
        if (rx_active === 1'b1) active_cnt++;
        if (rx_active === 1'b1 && active_prev !== 1'b1) rise_cyc = cyc;
        if (rx_active === 1'b0 && active_prev === 1'b1) fall_cyc = cyc;
        active_prev = rx_active;

        if (rx_valid === 1'b1 || rx_error === 1'b1) begin
            checks++;
            if ((rx_valid === 1'b1 && rx_error === 1'b1) || pulse_prev) begin
                errors++;
                $display("FAIL pulse_spacing cyc=%0d valid=%b error=%b prev_pulse=%b",
                         cyc, rx_valid, rx_error, pulse_prev);
            end
        end
        pulse_prev = (rx_valid === 1'b1) || (rx_error === 1'b1);
        if (rx_error === 1'b1) err_cnt++;

        if (rx_valid === 1'b1) begin
            valid_cnt++;
            valid_cycs.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d rx_data=%02h expected none", cyc, rx_data);
            end else begin
                mon_e = sb.pop_front();
                $display("rx byte cyc=%0d rx_data=%02h expected=%02h", cyc, rx_data, mon_e.data);
                if (rx_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL rx_data got=%02h expected=%02h", rx_data, mon_e.data);
                end
                if (mon_e.exp_cyc >= 0) begin
                    checks++;
                    if (cyc !== mon_e.exp_cyc) begin
                        errors++;
                        $display("FAIL valid_timing got_cyc=%0d expected_cyc=%0d", cyc, mon_e.exp_cyc);
                    end
                end
            end
        end
    end

    // ---------------- line driver ----------------
    logic [1:0] cur = LS_J;
    int         bp  = 16;
    int         ones_tx = 0;

    task automatic drive_line(input logic [1:0] ls, input int n);
        {d_p, d_n} = ls;
        repeat (n) @(negedge clk);
    endtask

    task automatic nrzi(input logic b);
        if (!b) cur = (cur == LS_J) ? LS_K : LS_J;
        drive_line(cur, bp);
    endtask

    // Returns the cycle at which the closing K of SYNC starts.
    task automatic send_sync(output int final_k_cyc);
        cur = LS_J;
        for (int i = 0; i < 7; i++) nrzi(1'b0);
        final_k_cyc = cyc;
        nrzi(1'b1);
        ones_tx = 0;
    endtask

    // Sends one byte LSB first with stuffing; the byte is expected 11 clocks
    // after its 8th data bit starts (2 sync + 8 to mid-bit + 1 register).
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) sb.push_back('{data: b, exp_cyc: (bp == 16) ? cyc + 11 : -1});
            nrzi(b[i]);
            if (b[i]) ones_tx++;
            else      ones_tx = 0;
            if (ones_tx == 6) begin
                nrzi(1'b0);
                ones_tx = 0;
            end
        end
    endtask

    // Two bit times of SE0 then one J; returns the cycle the J starts.
    task automatic send_eop(output int j_cyc);
        drive_line(LS_SE0, 2 * bp);
        j_cyc = cyc;
        cur   = LS_J;
        drive_line(LS_J, bp);
        drive_line(LS_J, 2 * bp);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        cur   = LS_J;
        drive_line(LS_J, 3);
        checks++;
        if ({rx_data, rx_valid, rx_active, rx_error} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%03h expected=000", {rx_data, rx_valid, rx_active, rx_error});
        end
        reset      = 1'b0;
        active_cnt = 0;
        valid_cnt  = 0;
        err_cnt    = 0;
        drive_line(LS_J, 100 * bp);
        checks++;
        if (active_cnt !== 0 || valid_cnt !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL idle_quiet active_cycles=%0d valids=%0d errors=%0d expected all 0",
                     active_cnt, valid_cnt, err_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_ack();
        int fk, jc, v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        checks++;
        if (rx_active !== 1'b0) begin
            errors++;
            $display("FAIL ack_active_before got=%b expected=0", rx_active);
        end
        send_sync(fk);
        checks++;
        if (rise_cyc !== fk + 11) begin
            errors++;
            $display("FAIL ack_active_rise got_cyc=%0d expected_cyc=%0d", rise_cyc, fk + 11);
        end
        send_byte(8'hD2);
        send_eop(jc);
        checks++;
        if (fall_cyc !== jc + 11 || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL ack_active_fall got_cyc=%0d active=%b expected_cyc=%0d active=0",
                     fall_cyc, rx_active, jc + 11);
        end
        checks++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL ack_counts valids=%0d errors=%0d pending=%0d expected 1/0/0",
                     valid_cnt - v0, err_cnt - e0, sb.size());
        end
        $display("test_ack done");
    endtask

    task automatic test_reset_mid();
        int fk;
        send_sync(fk);
        nrzi(1'b0);
        nrzi(1'b1);
        nrzi(1'b1);
        nrzi(1'b0);
        checks++;
        if (rx_active !== 1'b1) begin
            errors++;
            $display("FAIL mid_active_before_reset got=%b expected=1", rx_active);
        end
        reset = 1'b1;
        cur   = LS_J;
        drive_line(LS_J, 1);
        checks++;
        if ({rx_data, rx_valid, rx_active, rx_error} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%03h expected=000", {rx_data, rx_valid, rx_active, rx_error});
        end
        reset = 1'b0;
        drive_line(LS_J, 4 * bp);
        test_ack();
        $display("test_reset_mid done");
    endtask

    task automatic run_token(input int period, input logic check_gaps);
        int fk, jc, v0, e0;
        bp = period;
        drive_line(LS_J, 4 * bp);
        v0 = valid_cnt;
        e0 = err_cnt;
        valid_cycs.delete();
        send_sync(fk);
        send_byte(8'h2D);
        send_byte(8'h95);
        send_byte(8'h7E);
        send_eop(jc);
        checks++;
        if (valid_cnt - v0 !== 3 || err_cnt - e0 !== 0 || sb.size() !== 0 || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL token_bp%0d valids=%0d errors=%0d pending=%0d active=%b expected 3/0/0/0",
                     period, valid_cnt - v0, err_cnt - e0, sb.size(), rx_active);
        end
        if (check_gaps) begin
            checks++;
            if (valid_cycs.size() !== 3) begin
                errors++;
                $display("FAIL token_gap_count got=%0d expected=3", valid_cycs.size());
            end else if (valid_cycs[1] - valid_cycs[0] !== 128 || valid_cycs[2] - valid_cycs[1] !== 144) begin
                // 8'h7E carries a stuffed bit, so its gap is one bit longer.
                errors++;
                $display("FAIL token_gaps got=%0d,%0d expected=128,144",
                         valid_cycs[1] - valid_cycs[0], valid_cycs[2] - valid_cycs[1]);
            end
        end
        bp = 16;
        $display("token at %0d clk/bit done", period);
    endtask

    task automatic test_token();
        run_token(16, 1'b1);
    endtask

    task automatic test_stuffed_ff();
        int fk, jc, v0;
        drive_line(LS_J, 4 * bp);
        v0 = valid_cnt;
        valid_cycs.delete();
        send_sync(fk);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_eop(jc);
        checks++;
        if (valid_cnt - v0 !== 2 || valid_cycs.size() !== 2) begin
            errors++;
            $display("FAIL ff_count got=%0d expected=2", valid_cnt - v0);
        end else if (valid_cycs[1] - valid_cycs[0] !== 144 || valid_cycs[0] !== fk + 16 + 128 + 11) begin
            errors++;
            $display("FAIL ff_timing gap=%0d first=%0d expected gap=144 first=%0d",
                     valid_cycs[1] - valid_cycs[0], valid_cycs[0], fk + 155);
        end
        $display("test_stuffed_ff done");
    endtask

    task automatic test_stuff_error();
        int fk, jc, v0, e0;
        drive_line(LS_J, 4 * bp);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_sync(fk);
        send_byte(8'h2D);
        nrzi(1'b0);
        for (int i = 0; i < 7; i++) nrzi(1'b1);
        checks++;
        if (err_cnt - e0 !== 1 || rx_active !== 1'b1) begin
            errors++;
            $display("FAIL stuff_err_flag errors=%0d active=%b expected 1/1", err_cnt - e0, rx_active);
        end
        send_eop(jc);
        checks++;
        if (fall_cyc !== jc + 11 || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL stuff_err_fall got_cyc=%0d expected_cyc=%0d", fall_cyc, jc + 11);
        end
        checks++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 1 || sb.size() !== 0) begin
            errors++;
            $display("FAIL stuff_err_counts valids=%0d errors=%0d pending=%0d expected 1/1/0",
                     valid_cnt - v0, err_cnt - e0, sb.size());
        end
        $display("test_stuff_error done");
    endtask

    task automatic test_misaligned_eop();
        int fk, jc, v0, e0;
        drive_line(LS_J, 4 * bp);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_sync(fk);
        send_byte(8'h95);
        nrzi(1'b1);
        nrzi(1'b0);
        nrzi(1'b1);
        nrzi(1'b1);
        send_eop(jc);
        checks++;
        if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 1 || sb.size() !== 0) begin
            errors++;
            $display("FAIL misaligned_counts valids=%0d errors=%0d pending=%0d expected 1/1/0",
                     valid_cnt - v0, err_cnt - e0, sb.size());
        end
        checks++;
        if (fall_cyc !== jc + 11 || rx_active !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_fall got_cyc=%0d expected_cyc=%0d", fall_cyc, jc + 11);
        end
        $display("test_misaligned_eop done");
    endtask

    task automatic test_drift();
        run_token(15, 1'b0);
        run_token(17, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_reset_mid();
        test_token();
        test_stuffed_ff();
        test_stuff_error();
        test_misaligned_eop();
        test_drift();
        drive_line(LS_J, 4 * bp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
